// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the segment scan multiplexer.
package seg_scan_pkg;

  localparam int DUTY_W     = 4;
  localparam int MAX_DIGITS = 32;

  function automatic int idx_w(input int digits);
    int w;
    w = $clog2(digits);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned n);
    logic [MAX_DIGITS-1:0] one;
    one    = {{(MAX_DIGITS-1){1'b0}}, 1'b1};
    onehot = one << n;
  endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Divides clk into one registered tick per DIV cycles; tick_ahead flags the cycle before.
module seg_scan_prescaler #(
  parameter int DIV = 5000
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic tick_ahead
);

  localparam int CNT_W = (DIV <= 2) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  assign tick_ahead = (cnt_r == CNT_PRE);
  assign tick       = tick_r;

  // Slot counter; tick is registered so it is high exactly while cnt_r is at its last value
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= (cnt_r == CNT_LAST) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      tick_r <= tick_ahead;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit segment driver with frame-synchronous double buffering.
// Optional PWM dimming via a duty input when SEG_SCAN_DIM_EN is defined.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int SEG_W  = 7,
  parameter int DIV    = 5000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIGITS*SEG_W-1:0] digits_in,
  input  logic                    load,
  input  logic [DIGITS-1:0]       en_mask,
`ifdef SEG_SCAN_DIM_EN
  input  logic [DUTY_W-1:0]       duty,
`endif
  output logic [SEG_W-1:0]        segment,
  output logic [DIGITS-1:0]       digit_en,
  output logic                    tick,
  output logic                    frame_done
);

  localparam int IW = idx_w(DIGITS);
  localparam int FW = DIGITS * SEG_W;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic                  tick_s;
  logic                  tick_ahead_s;
  logic [IW-1:0]         idx_r;
  logic [IW-1:0]         idx_next_s;
  logic                  wrap_s;
  logic [FW-1:0]         shadow_r;
  logic [FW-1:0]         shadow_next_s;
  logic [FW-1:0]         pending_r;
  logic [FW-1:0]         pending_next_s;
  logic                  pend_v_r;
  logic                  pend_v_next_s;
  logic [MAX_DIGITS-1:0] onehot_s;
  logic [DIGITS-1:0]     scan_sel_r;
  logic [DIGITS-1:0]     scan_sel_next_s;
  logic [SEG_W-1:0]      segment_r;
  logic [SEG_W-1:0]      segment_next_s;
  logic                  frame_done_r;

  seg_scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick_s),
    .tick_ahead (tick_ahead_s)
  );

  // Next scan index, buffer swap and the pattern/select latched at each slot boundary
  always_comb begin
    idx_next_s      = idx_r;
    wrap_s          = 1'b0;
    shadow_next_s   = shadow_r;
    pending_next_s  = pending_r;
    pend_v_next_s   = pend_v_r;
    onehot_s        = {MAX_DIGITS{1'b0}};
    scan_sel_next_s = scan_sel_r;
    segment_next_s  = segment_r;

    if (tick_s) begin
      if (idx_r == IDX_LAST) begin
        idx_next_s = {IW{1'b0}};
        wrap_s     = 1'b1;
      end else begin
        idx_next_s = idx_r + IW'(1);
      end
    end else begin
      idx_next_s = idx_r;
    end

    // A load coinciding with the wrap bypasses the pending buffer entirely
    if (wrap_s && load) begin
      shadow_next_s = digits_in;
      pend_v_next_s = 1'b0;
    end else if (wrap_s && pend_v_r) begin
      shadow_next_s = pending_r;
      pend_v_next_s = 1'b0;
    end else if (load) begin
      pending_next_s = digits_in;
      pend_v_next_s  = 1'b1;
    end else begin
      pending_next_s = pending_r;
    end

    if (tick_s) begin
      onehot_s        = onehot(32'(idx_next_s));
      scan_sel_next_s = en_mask[idx_next_s] ? onehot_s[DIGITS-1:0] : {DIGITS{1'b0}};
      segment_next_s  = shadow_next_s[int'(idx_next_s)*SEG_W +: SEG_W];
    end else begin
      scan_sel_next_s = scan_sel_r;
      segment_next_s  = segment_r;
    end
  end

  // Scan state, frame buffers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r        <= {IW{1'b0}};
      shadow_r     <= {FW{1'b0}};
      pending_r    <= {FW{1'b0}};
      pend_v_r     <= 1'b0;
      scan_sel_r   <= {DIGITS{1'b0}};
      segment_r    <= {SEG_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      idx_r        <= idx_next_s;
      shadow_r     <= shadow_next_s;
      pending_r    <= pending_next_s;
      pend_v_r     <= pend_v_next_s;
      scan_sel_r   <= scan_sel_next_s;
      segment_r    <= segment_next_s;
      frame_done_r <= tick_ahead_s && (idx_r == IDX_LAST);
    end
  end

  assign segment    = segment_r;
  assign tick       = tick_s;
  assign frame_done = frame_done_r;

`ifdef SEG_SCAN_DIM_EN
  logic [DUTY_W-1:0] pwm_r;
  logic [DIGITS-1:0] digit_en_r;
  logic              gate_s;

  // Full scale (all ones) means always on rather than 15/16 brightness
  always_comb begin
    gate_s = (pwm_r < duty) || (duty == {DUTY_W{1'b1}});
  end

  // Free-running PWM phase and the gated digit select
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_r      <= {DUTY_W{1'b0}};
      digit_en_r <= {DIGITS{1'b0}};
    end else begin
      pwm_r      <= pwm_r + DUTY_W'(1);
      digit_en_r <= scan_sel_next_s & {DIGITS{gate_s}};
    end
  end

  assign digit_en = digit_en_r;
`else
  assign digit_en = scan_sel_r;
`endif

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised time-multiplexed driver for an N-digit common-anode/cathode segment display. A prescaler divides `clk` into a per-digit slot tick, and a scan counter walks the digit index round-robin, driving one digit-enable and its segment pattern per slot. Display data is double-buffered and only swapped at frame boundaries, so the display never tears. The block sits between the display-formatting logic and the board pins, and generalises the two-digit scanner to any digit count and slot length.

## Interface
- `DIGITS`, default 4: number of multiplexed digits; valid range ≥2.
- `SEG_W`, default 7: segment bits per digit; 8 when a decimal point is included.
- `DIV`, default 5000: clock cycles per digit slot; valid range ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `digits_in`  in  DIGITS*SEG_W  new frame; digit k occupies bits [k*SEG_W +: SEG_W].
- `load`  in  1  single-cycle strobe that captures `digits_in`.
- `en_mask`  in  DIGITS  per-digit enable; a 0 bit blanks that digit's slot.
- `segment`  out  SEG_W  segment pattern of the current digit (registered).
- `digit_en`  out  DIGITS  one-hot or all-zero digit select (registered).
- `tick`  out  1  one-cycle pulse at each slot boundary.
- `frame_done`  out  1  one-cycle pulse when the index wraps from DIGITS-1 to 0.
- `duty`  in  4  brightness; present only with `SEG_SCAN_DIM_EN`.

## Operation
- Prescaler `cnt` counts 0..DIV-1 and wraps to 0. `tick`=1 exactly in the cycle `cnt`==DIV-1.
- Scan index `idx` has width clog2(DIGITS). On each tick, `idx` advances, and goes from DIGITS-1 to 0 on wrap.
- Registers:
  - `pending` (holds the captured frame)
  - `pend_v` (pending flag)
  - `shadow` (the displayed frame)
- `load`=1 writes `digits_in` into `pending` and sets `pend_v`. A later `load` before the swap overwrites `pending` (the newest frame wins).
- Frame swap happens on the wrap tick: if `pend_v`, then `shadow`←`pending` and `pend_v` clears.
- `load` in the same cycle as the wrap tick: `digits_in` goes directly into `shadow` and `pend_v` clears.
- On each tick, with new index n:
  - `segment`←`shadow`[n], using the post-swap `shadow` on a wrap tick.
  - `digit_en`←onehot(n) if `en_mask`[n], else 0. A blanked digit still consumes its slot, so timing stays uniform.
- `en_mask` is sampled only at ticks.
- Liveness: with `rst` eventually held low, every digit with `en_mask`=1 is selected infinitely often, once per DIGITS*DIV cycles.

## Timing
- Reset values: `cnt`=0, `idx`=0, `segment`=0, `digit_en`=0, `tick`=0, `frame_done`=0, `shadow`=0, `pending`=0, `pend_v`=0.
- `rst` takes priority over everything, including a coincident `load` or tick. Reset mid-frame discards the pending data.
- After reset is released, the first tick occurs at cycle DIV-1. It selects digit 1, not 0, because the index advances before driving.
- `segment` and `digit_en` update in the cycle after `tick`, since both are registered from the same edge as `tick`.
- `frame_done` coincides with the wrap tick.
- A `load` becomes visible on the outputs no later than DIGITS*DIV+1 cycles after the strobe.

## Configuration
- `SEG_SCAN_DIM_EN` defined:
  - Adds the `duty` port and a free-running 4-bit counter `pwm` (reset 0, increments every cycle).
  - `digit_en` is ANDed with (`pwm` < `duty` || `duty`==15).
  - `duty`=0 gives a fully dark display while scanning and `tick` continue.
- `SEG_SCAN_DIM_EN` undefined: no `duty` port, no PWM logic, and `digit_en` is always as scanned.

## Structure
- Package `seg_scan_pkg`:
  - function `idx_w(DIGITS)` (clog2, minimum 1)
  - function `onehot`
  - localparam `DUTY_W`=4
- Sub-module `seg_scan_prescaler` (parameter `DIV`): outputs `tick`.
- Top-level contents: buffers, scan index, output registers, optional PWM.

## Test plan
All cases use DIGITS=4, SEG_W=7, DIV=4 unless stated.
- Reset then idle: `tick` at cycles 3, 7, 11, 15. `digit_en` sequence is 0010, 0100, 1000, 0001. `frame_done` at cycle 15. `segment`=0 throughout.
- `load` with digits 0x01, 0x02, 0x04, 0x08 at cycle 5: shown from the wrap tick at cycle 15, so digit 0 shows 0x01 at cycle 16. The old value of 0 is shown before that.
- `load` exactly at the wrap-tick cycle, with a second `load` 2 cycles earlier carrying different data: the wrap-cycle data is displayed and `pend_v`=0 afterwards.
- `en_mask`=1011: digit 2's slot has `digit_en`=0000 while `segment` still carries digit 2's pattern. Slot timing is unchanged.
- `rst` asserted mid-frame at idx=2 with `pend_v`=1: all outputs return to reset values the next cycle and the pending data is never displayed.
- With `SEG_SCAN_DIM_EN`:
  - `duty`=4: `digit_en` is nonzero exactly 4 of every 16 cycles (use DIV=32).
  - `duty`=0: `digit_en` stays 0 while `tick` continues.
  - `duty`=15: `digit_en` is always on.
